// File: rtl/cr16_control_fsm.sv
// Multicycle control sequencer for the 16-bit CPU: owns the IR and drives register file,
// ALU, PSR, PC and BRAM controls one state per cycle.
module cr16_control_fsm #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned REGBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [WIDTH-1:0]   instr,
  input  logic               cond_met,
  output logic [WIDTH-1:0]   ir_out,
  output logic               rf_we,
  output logic [REGBITS-1:0] rf_dst_addr,
  output logic [REGBITS-1:0] rf_src_addr,
  output logic               rf_wsel,
  output logic [3:0]         alu_op,
  output logic               alu_b_sel,
  output logic [WIDTH-1:0]   imm_out,
  output logic               flags_en,
  output logic               pc_en,
  output logic [1:0]         pc_src,
  output logic               mem_addr_sel,
  output logic               mem_we,
  output logic               illegal_op,
  output logic [2:0]         state_out
);

  typedef enum logic [2:0] {
    StFetch = 3'd0,
    StLatch = 3'd1,
    StRegrd = 3'd2,
    StExec  = 3'd3,
    StMemrd = 3'd4,
    StWb    = 3'd5
  } state_e;

  localparam logic [3:0] OpRtype  = 4'h0;
  localparam logic [3:0] OpMem    = 4'h4;
  localparam logic [3:0] OpBcond  = 4'hC;
  localparam logic [3:0] OpLui    = 4'hF;
  localparam logic [3:0] ExtLoad  = 4'h0;
  localparam logic [3:0] ExtStor  = 4'h4;
  localparam logic [3:0] ExtJcond = 4'hC;
  localparam logic [3:0] CodeAnd  = 4'h1;
  localparam logic [3:0] CodeOr   = 4'h2;
  localparam logic [3:0] CodeXor  = 4'h3;
  localparam logic [3:0] CodeAdd  = 4'h5;
  localparam logic [3:0] CodeSub  = 4'h9;
  localparam logic [3:0] CodeCmp  = 4'hB;
  localparam logic [3:0] CodeMov  = 4'hD;

  localparam int unsigned PcSrcInc = 0;
  localparam int unsigned PcSrcReg = 1;
  localparam int unsigned PcSrcRel = 2;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ir_q, ir_d;

  logic [3:0] op, ext, alu_code;
  logic       is_rtype, is_itype, is_alu, is_load, is_stor, is_jcond, is_bcond, legal;

  function automatic logic is_alu_code(input logic [3:0] c);
    case (c)
      CodeAnd, CodeOr, CodeXor, CodeAdd, CodeSub, CodeCmp, CodeMov: is_alu_code = 1'b1;
      default:                                                     is_alu_code = 1'b0;
    endcase
  endfunction

  assign op  = ir_q[WIDTH-1 -: 4];
  assign ext = ir_q[7:4];

  assign is_rtype = (op == OpRtype) && is_alu_code(ext);
  assign is_itype = is_alu_code(op) || (op == OpLui);
  assign is_alu   = is_rtype || is_itype;
  assign alu_code = is_rtype ? ext : op;
  assign is_load  = (op == OpMem) && (ext == ExtLoad);
  assign is_stor  = (op == OpMem) && (ext == ExtStor);
  assign is_jcond = (op == OpMem) && (ext == ExtJcond);
  assign is_bcond = (op == OpBcond);
  assign legal    = is_alu || is_load || is_stor || is_jcond || is_bcond;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      StFetch: if (run) state_d = StLatch;
      StLatch: begin
        ir_d    = instr;
        state_d = StRegrd;
      end
      StRegrd: state_d = legal ? StExec : StFetch;
      StExec:  state_d = is_load ? StMemrd : StFetch;
      StMemrd: state_d = StWb;
      StWb:    state_d = StFetch;
      default: state_d = StFetch;
    endcase
  end

  // Datapath decode that does not depend on state
  always_comb begin
    if (op == OpLui) begin
      imm_out = {ir_q[7:0], {(WIDTH-8){1'b0}}};
    end else if (op == CodeAnd || op == CodeOr || op == CodeXor) begin
      imm_out = {{(WIDTH-8){1'b0}}, ir_q[7:0]};
    end else begin
      imm_out = {{(WIDTH-8){ir_q[7]}}, ir_q[7:0]};
    end
    if (is_rtype) begin
      alu_op = ext;
    end else if (op == OpLui) begin
      alu_op = CodeMov;
    end else begin
      alu_op = op;
    end
    alu_b_sel = ~is_rtype;
  end

  // Per-state control outputs
  always_comb begin
    rf_we        = 1'b0;
    rf_wsel      = 1'b0;
    flags_en     = 1'b0;
    pc_en        = 1'b0;
    pc_src       = 2'(PcSrcInc);
    mem_addr_sel = 1'b0;
    mem_we       = 1'b0;
    illegal_op   = 1'b0;
    unique case (state_q)
      StFetch: mem_addr_sel = 1'b0;
      StLatch: pc_en = 1'b1;
      StRegrd: illegal_op = ~legal;
      StExec: begin
        if (is_alu) begin
          rf_we    = (alu_code != CodeCmp);
          flags_en = (alu_code == CodeAdd) || (alu_code == CodeSub) || (alu_code == CodeCmp);
        end
        if (is_load || is_stor) mem_addr_sel = 1'b1;
        if (is_stor) mem_we = 1'b1;
        if (is_jcond && cond_met) begin
          pc_en  = 1'b1;
          pc_src = 2'(PcSrcReg);
        end
        if (is_bcond && cond_met) begin
          pc_en  = 1'b1;
          pc_src = 2'(PcSrcRel);
        end
      end
      StMemrd: mem_addr_sel = 1'b1;
      StWb: begin
        rf_we   = 1'b1;
        rf_wsel = 1'b1;
      end
      default: ;
    endcase
    // Reset aborts whatever instruction is in flight without any side effect
    if (reset) begin
      rf_we      = 1'b0;
      flags_en   = 1'b0;
      pc_en      = 1'b0;
      mem_we     = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign ir_out      = ir_q;
  assign rf_dst_addr = ir_q[8 +: REGBITS];
  assign rf_src_addr = ir_q[REGBITS-1:0];
  assign state_out   = state_q;

endmodule

// File: tb/tb_cr16_control_fsm.sv
// Directed bench for cr16_control_fsm: an instruction-level model expands each instruction into
// its expected per-cycle control trace, and one compare process checks the DUT every cycle.
module tb_cr16_control_fsm;

  logic        clk = 1'b0;
  logic        reset, run, cond_met;
  logic [15:0] instr;
  logic [15:0] ir_out, imm_out;
  logic        rf_we, rf_wsel, alu_b_sel, flags_en, pc_en, mem_addr_sel, mem_we, illegal_op;
  logic [3:0]  rf_dst_addr, rf_src_addr, alu_op;
  logic [1:0]  pc_src;
  logic [2:0]  state_out;

  int checks = 0;
  int errors = 0;

  cr16_control_fsm #(.WIDTH(16), .REGBITS(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .instr        (instr),
    .cond_met     (cond_met),
    .ir_out       (ir_out),
    .rf_we        (rf_we),
    .rf_dst_addr  (rf_dst_addr),
    .rf_src_addr  (rf_src_addr),
    .rf_wsel      (rf_wsel),
    .alu_op       (alu_op),
    .alu_b_sel    (alu_b_sel),
    .imm_out      (imm_out),
    .flags_en     (flags_en),
    .pc_en        (pc_en),
    .pc_src       (pc_src),
    .mem_addr_sel (mem_addr_sel),
    .mem_we       (mem_we),
    .illegal_op   (illegal_op),
    .state_out    (state_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] ir;
    logic        we, wsel, fl, pcen;
    logic [1:0]  pcsrc;
    logic        mas_care, mas, mwe, ill;
    logic        alu_care;
    logic [3:0]  aop;
    logic        bsel;
    logic        imm_care;
    logic [15:0] imm;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e_cur;
  logic [15:0] model_ir;

  localparam logic [3:0] ALU_CODES [7] = '{4'h5, 4'h9, 4'hB, 4'h1, 4'h2, 4'h3, 4'hD};

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, want);
    end
  endtask

  function automatic logic in_alu_table(input logic [3:0] c);
    logic hit = 1'b0;
    for (int i = 0; i < 7; i++) if (ALU_CODES[i] == c) hit = 1'b1;
    return hit;
  endfunction

  // 0 illegal, 1 ALU reg, 2 ALU imm, 3 load, 4 store, 5 jcond, 6 bcond
  function automatic int klass(input logic [15:0] w);
    if (w[15:12] == 4'h0 && in_alu_table(w[7:4])) return 1;
    if (in_alu_table(w[15:12]) || w[15:12] == 4'hF) return 2;
    if (w[15:12] == 4'h4 && w[7:4] == 4'h0) return 3;
    if (w[15:12] == 4'h4 && w[7:4] == 4'h4) return 4;
    if (w[15:12] == 4'h4 && w[7:4] == 4'hC) return 5;
    if (w[15:12] == 4'hC) return 6;
    return 0;
  endfunction

  function automatic exp_t mk(input logic [2:0] st, input logic [15:0] ir);
    exp_t e = '0;
    e.st = st;
    e.ir = ir;
    return e;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_cur = exp_q.pop_front();
      chk("state_out", 16'(state_out), 16'(e_cur.st));
      chk("ir_out", ir_out, e_cur.ir);
      chk("rf_dst_addr", 16'(rf_dst_addr), 16'(e_cur.ir[11:8]));
      chk("rf_src_addr", 16'(rf_src_addr), 16'(e_cur.ir[3:0]));
      chk("rf_we", 16'(rf_we), 16'(e_cur.we));
      chk("flags_en", 16'(flags_en), 16'(e_cur.fl));
      chk("pc_en", 16'(pc_en), 16'(e_cur.pcen));
      chk("mem_we", 16'(mem_we), 16'(e_cur.mwe));
      chk("illegal_op", 16'(illegal_op), 16'(e_cur.ill));
      if (e_cur.we) chk("rf_wsel", 16'(rf_wsel), 16'(e_cur.wsel));
      if (e_cur.pcen) chk("pc_src", 16'(pc_src), 16'(e_cur.pcsrc));
      if (e_cur.mas_care) chk("mem_addr_sel", 16'(mem_addr_sel), 16'(e_cur.mas));
      if (e_cur.alu_care) begin
        chk("alu_op", 16'(alu_op), 16'(e_cur.aop));
        chk("alu_b_sel", 16'(alu_b_sel), 16'(e_cur.bsel));
      end
      if (e_cur.imm_care) chk("imm_out", imm_out, e_cur.imm);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at the start of a FETCH cycle; queues the whole expected trace of one instruction.
  task automatic start_instr(input logic [15:0] w, input logic c, input logic abort_wb,
                             output int n);
    int         k = klass(w);
    logic [3:0] code;
    exp_t       e;
    instr = w;
    cond_met = c;
    run = 1'b1;
    e = mk(3'd0, model_ir); e.mas_care = 1'b1; exp_q.push_back(e);
    e = mk(3'd1, model_ir); e.pcen = 1'b1; exp_q.push_back(e);
    model_ir = w;
    e = mk(3'd2, w); e.ill = (k == 0); exp_q.push_back(e);
    n = 3;
    if (k != 0) begin
      e = mk(3'd3, w);
      n = 4;
      if (k == 1 || k == 2) begin
        code = (k == 1) ? w[7:4] : w[15:12];
        e.alu_care = 1'b1;
        e.bsel = (k == 2);
        e.aop = (code == 4'hF) ? 4'hD : code;
        e.we = (code != 4'hB);
        e.fl = (code == 4'h5) || (code == 4'h9) || (code == 4'hB);
        if (k == 2) begin
          e.imm_care = 1'b1;
          if (code == 4'hF) e.imm = {w[7:0], 8'h00};
          else if (code == 4'h1 || code == 4'h2 || code == 4'h3) e.imm = {8'h00, w[7:0]};
          else e.imm = {{8{w[7]}}, w[7:0]};
        end
      end else if (k == 3 || k == 4) begin
        e.mas_care = 1'b1;
        e.mas = 1'b1;
        e.mwe = (k == 4);
      end else if (c) begin
        e.pcen = 1'b1;
        e.pcsrc = (k == 5) ? 2'd1 : 2'd2;
      end
      exp_q.push_back(e);
      if (k == 3) begin
        e = mk(3'd4, w); e.mas_care = 1'b1; e.mas = 1'b1; exp_q.push_back(e);
        e = mk(3'd5, w);
        if (!abort_wb) begin
          e.we = 1'b1;
          e.wsel = 1'b1;
        end
        exp_q.push_back(e);
        n = 6;
      end
    end
  endtask

  task automatic do_instr(input logic [15:0] w, input logic c);
    int n;
    start_instr(w, c, 1'b0, n);
    wait_cycles(n);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    run = 1'b0;
    cond_met = 1'b0;
    instr = 16'h0000;
    model_ir = 16'h0000;
    wait_cycles(3);
    chk("reset_state", 16'(state_out), 16'd0);
    chk("reset_ir", ir_out, 16'h0000);
    chk("reset_rf_we", 16'(rf_we), 16'd0);
    chk("reset_pc_en", 16'(pc_en), 16'd0);
    reset = 1'b0;

    // run=0 holds in FETCH
    for (int i = 0; i < 12; i++) begin
      exp_t e = mk(3'd0, model_ir);
      e.mas_care = 1'b1;
      exp_q.push_back(e);
    end
    wait_cycles(12);
    chk("idle_state", 16'(state_out), 16'd0);

    // ADD R2,R3: EXEC is the fourth cycle
    start_instr(16'h0253, 1'b0, 1'b0, n);
    wait_cycles(3);
    chk("add_state", 16'(state_out), 16'd3);
    chk("add_rf_we", 16'(rf_we), 16'd1);
    chk("add_alu_op", 16'(alu_op), 16'h5);
    chk("add_b_sel", 16'(alu_b_sel), 16'd0);
    chk("add_flags", 16'(flags_en), 16'd1);
    chk("add_dst", 16'(rf_dst_addr), 16'd2);
    chk("add_src", 16'(rf_src_addr), 16'd3);
    wait_cycles(1);

    start_instr(16'h1180, 1'b0, 1'b0, n);
    wait_cycles(3);
    chk("andi_imm", imm_out, 16'h0080);
    chk("andi_flags", 16'(flags_en), 16'd0);
    wait_cycles(1);
    start_instr(16'h5180, 1'b0, 1'b0, n);
    wait_cycles(3);
    chk("addi_imm", imm_out, 16'hFF80);
    wait_cycles(1);
    start_instr(16'hF112, 1'b0, 1'b0, n);
    wait_cycles(3);
    chk("lui_imm", imm_out, 16'h1200);
    chk("lui_alu_op", 16'(alu_op), 16'hD);
    wait_cycles(1);

    do_instr(16'h0953, 1'b1);
    do_instr(16'h0B53, 1'b0);
    do_instr(16'hB1FF, 1'b0);
    do_instr(16'h31F0, 1'b0);
    do_instr(16'h2A7F, 1'b0);
    do_instr(16'h0D12, 1'b0);
    do_instr(16'h0221, 1'b0);
    do_instr(16'hD7C3, 1'b0);

    // LOAD R4,R5
    start_instr(16'h4405, 1'b0, 1'b0, n);
    wait_cycles(3);
    chk("ld_exec_mas", 16'(mem_addr_sel), 16'd1);
    chk("ld_exec_we", 16'(rf_we), 16'd0);
    wait_cycles(1);
    chk("ld_memrd_mas", 16'(mem_addr_sel), 16'd1);
    wait_cycles(1);
    chk("ld_wb_state", 16'(state_out), 16'd5);
    chk("ld_wb_we", 16'(rf_we), 16'd1);
    chk("ld_wb_wsel", 16'(rf_wsel), 16'd1);
    wait_cycles(1);

    start_instr(16'h4445, 1'b0, 1'b0, n);
    wait_cycles(3);
    chk("st_mem_we", 16'(mem_we), 16'd1);
    wait_cycles(1);
    chk("st_after_mem_we", 16'(mem_we), 16'd0);

    start_instr(16'hC0FE, 1'b1, 1'b0, n);
    wait_cycles(3);
    chk("b_taken_pc_en", 16'(pc_en), 16'd1);
    chk("b_taken_pc_src", 16'(pc_src), 16'd2);
    wait_cycles(1);
    start_instr(16'hC0FE, 1'b0, 1'b0, n);
    wait_cycles(3);
    chk("b_nottaken_pc_en", 16'(pc_en), 16'd0);
    wait_cycles(1);
    do_instr(16'h4AC7, 1'b1);
    do_instr(16'h4AC7, 1'b0);

    start_instr(16'h0070, 1'b0, 1'b0, n);
    wait_cycles(2);
    chk("ill_pulse", 16'(illegal_op), 16'd1);
    chk("ill_rf_we", 16'(rf_we), 16'd0);
    wait_cycles(1);
    chk("ill_back_fetch", 16'(state_out), 16'd0);
    chk("ill_pulse_end", 16'(illegal_op), 16'd0);
    do_instr(16'h4410, 1'b0);
    do_instr(16'h0000, 1'b0);

    // Reset during WB of a LOAD aborts the write
    start_instr(16'h4405, 1'b0, 1'b1, n);
    wait_cycles(5);
    reset = 1'b1;
    wait_cycles(1);
    chk("abort_state", 16'(state_out), 16'd0);
    chk("abort_rf_we", 16'(rf_we), 16'd0);
    chk("abort_ir", ir_out, 16'h0000);
    reset = 1'b0;
    model_ir = 16'h0000;
    do_instr(16'h0253, 1'b0);
    do_instr(16'h4405, 1'b0);

    run = 1'b0;
    wait_cycles(2);
    chk("trace_drained", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cr16_control_fsm.md
Name: cr16_control_fsm

Overview:
- Multicycle sequencer for the 16-bit CPU datapath.
- Owns the instruction register (IR).
- Drives the register file ports (srcAddr, dstAddr, writeEn) from the IR.
- Drives ALU op/operand select, flags enable, PC update and BRAM address/write controls, one state per cycle.
- The register file has registered reads, so data driven out in one state is consumed by the next.

Parameters:
- WIDTH, 16, datapath/instruction width
- REGBITS, 4, register address width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- run  in  1  1 allows a new fetch; 0 holds in FETCH
- instr  in  WIDTH  BRAM read data (instruction or load data)
- cond_met  in  1  condition unit result for IR[11:8] against the PSR
- ir_out  out  WIDTH  current IR
- rf_we  out  1  register file writeEn
- rf_dst_addr  out  REGBITS  IR[11:8]; also the write address
- rf_src_addr  out  REGBITS  IR[3:0]
- rf_wsel  out  1  write data select: 0 ALU, 1 memory
- alu_op  out  4  ALU operation code
- alu_b_sel  out  1  ALU B operand: 0 register, 1 imm_out
- imm_out  out  WIDTH  extended immediate
- flags_en  out  1  PSR load enable
- pc_en  out  1  PC load enable
- pc_src  out  2  PC source: 0 PC+1, 1 register readData1, 2 PC+sext(IR[7:0])
- mem_addr_sel  out  1  BRAM address: 0 PC, 1 readData2 (Rsrc)
- mem_we  out  1  BRAM write enable (data = readData1)
- illegal_op  out  1  one-cycle pulse on an undecodable IR
- state_out  out  3  current state, for debug

Behaviour:
- Reset (synchronous, highest priority, any state):
  - state=FETCH, IR=0.
  - All enables (rf_we, flags_en, pc_en, mem_we, illegal_op) are 0 in the reset cycle, so an in-flight instruction is aborted with no write.
- Encodings:
  - op=IR[15:12], ext=IR[7:4].
  - R-type: op 0000; ext ADD 0101, SUB 1001, CMP 1011, AND 0001, OR 0010, XOR 0011, MOV 1101.
  - I-type: op equals that ext code; LUI is op 1111.
  - LOAD: op 0100, ext 0000. STOR: op 0100, ext 0100. Jcond: op 0100, ext 1100. Bcond: op 1100.
- States and transitions:
  - FETCH(0): mem_addr_sel=0. If run, go to LATCH; else stay.
  - LATCH(1): IR<=instr; pc_en=1, pc_src=0. Go to REGRD.
  - REGRD(2): register addresses are stable from the IR; the register file captures operands this cycle. Go to EXEC; an illegal encoding goes to FETCH with illegal_op=1.
  - EXEC(3), ALU ops:
    - R-type: alu_b_sel=0, alu_op=ext. I-type: alu_b_sel=1, alu_op=op.
    - rf_we=1 except CMP/CMPI.
    - flags_en=1 for ADD/SUB/CMP and their immediate forms only.
    - Next state FETCH.
  - EXEC(3), LOAD: mem_addr_sel=1; go to MEMRD.
  - EXEC(3), STOR: mem_addr_sel=1, mem_we=1; go to FETCH.
  - EXEC(3), Jcond: if cond_met, pc_en=1, pc_src=1. Go to FETCH.
  - EXEC(3), Bcond: if cond_met, pc_en=1, pc_src=2. Go to FETCH.
  - MEMRD(4): mem_addr_sel=1 held; BRAM latency cycle. Go to WB.
  - WB(5): rf_we=1, rf_wsel=1. Go to FETCH.
- Immediate extension:
  - AND/OR/XOR immediates are zero-extended IR[7:0].
  - LUI gives {IR[7:0], 8'h00} with alu_op=1101 (MOV).
  - All other immediates are sign-extended.
- Latency:
  - ALU, STOR, J, B: 4 cycles.
  - LOAD: 6 cycles.
  - PC is already incremented before any branch; the branch target is PC+1+disp relative to the instruction.
- Outputs are decoded combinationally from state and IR. All enables are 0 unless stated above.
- run is sampled only in FETCH.

Test Plan:
- Reset mid-operation: reset asserted during WB of a LOAD -> next cycle state_out=0, rf_we=0; IR=0.
- ADD R2,R3 (0x0253) with run=1 -> EXEC on cycle 4: rf_we=1, alu_op=0101, alu_b_sel=0, flags_en=1, rf_dst_addr=2, rf_src_addr=3.
- ANDI R1,0x80 (0x1180) -> imm_out=0x0080. ADDI R1,0x80 (0x5180) -> imm_out=0xFF80. LUI R1,0x12 (0xF112) -> imm_out=0x1200, alu_op=1101.
- LOAD R4,R5 (0x4405) -> mem_addr_sel=1 in EXEC and MEMRD; rf_we=1, rf_wsel=1 only in WB (cycle 6). STOR (0x4445) -> mem_we=1 for exactly 1 cycle, rf_we never 1.
- Bcond 0xC0FE: cond_met=1 -> pc_en=1, pc_src=2 in EXEC. cond_met=0 -> pc_en=0 in EXEC, only the LATCH increment occurs.
- Illegal 0x0070 -> illegal_op=1 for 1 cycle in REGRD, no writes, returns to FETCH. With run=0, state stays 0 for 10+ cycles.
